hazard_scoreboard: RTL and testbench



---
 rtl/hazard_scoreboard_if.sv | 37 +++
 rtl/hazard_scoreboard.sv | 121 ++++++++++++
 tb/tb_hazard_scoreboard.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_if.sv
// ID-stage hazard query and stall-control bundle between the decode side and the scoreboard.
// master drives the ID instruction fields and freeze/flush requests; slave returns enables and debug counts.
interface hazard_scoreboard_if #(
    parameter int NSTAGE = 5,
    parameter int CNT_W  = 32
);
    logic              id_valid;
    logic [4:0]        rs1_id;
    logic [4:0]        rs2_id;
    logic              rs1_used;
    logic              rs2_used;
    logic [4:0]        rd_id;
    logic              rd_we_id;
    logic              is_load_id;
    logic              is_md_id;
    logic              stall_pipeline;
    logic              flush;
    logic [NSTAGE-1:0] load_en;
    logic              ctrlmux_sel;
    logic              cur_stall;
    logic [1:0]        sd;
    logic [CNT_W-1:0]  raw_stalls;
    logic [CNT_W-1:0]  mem_stalls;
    logic [CNT_W-1:0]  md_stalls;

    modport master (
        output id_valid, rs1_id, rs2_id, rs1_used, rs2_used, rd_id, rd_we_id,
               is_load_id, is_md_id, stall_pipeline, flush,
        input  load_en, ctrlmux_sel, cur_stall, sd, raw_stalls, mem_stalls, md_stalls
    );

    modport slave (
        input  id_valid, rs1_id, rs2_id, rs1_used, rs2_used, rd_id, rd_we_id,
               is_load_id, is_md_id, stall_pipeline, flush,
        output load_en, ctrlmux_sel, cur_stall, sd, raw_stalls, mem_stalls, md_stalls
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard producing RAW / mul-div-busy / memory stalls for the ID stage.
// Latency: outputs are combinational from scoreboard state and current ID inputs (zero cycles).
// Backpressure: stall_pipeline freezes every stage and all scoreboard state; RAW/busy hold PC and IF/ID only.
module hazard_scoreboard #(
    parameter int NSTAGE       = 5,
    parameter int LOAD_BUBBLES = 1,
    parameter int MD_LAT       = 4,
    parameter int CNT_W        = 32
) (
    input logic                clk,
    input logic                rst_n,
    hazard_scoreboard_if.slave sb
);
    localparam int MAX_LAT = (LOAD_BUBBLES > MD_LAT) ? LOAD_BUBBLES : MD_LAT;
    localparam int TW      = $clog2(MAX_LAT + 1);

    localparam logic [1:0] SD_NONE = 2'd0;
    localparam logic [1:0] SD_RAW  = 2'd1;
    localparam logic [1:0] SD_MEM  = 2'd2;
    localparam logic [1:0] SD_BUSY = 2'd3;

    typedef logic [TW-1:0] tmr_t;

    tmr_t             cnt [1:31];
    tmr_t             md_busy;
    logic [31:0]      pend_vec;
    logic             raw;
    logic             busy;
    logic             fire;
    tmr_t             issue_lat;
    logic [NSTAGE-1:0] load_en;
    logic             ctrlmux_sel;
    logic [1:0]       sd;
    logic [CNT_W-1:0] raw_stalls;
    logic [CNT_W-1:0] mem_stalls;
    logic [CNT_W-1:0] md_stalls;

    // x0 never has an entry, so its pending bit is tied low.
    always_comb begin
        pend_vec    = '0;
        for (int i = 1; i < 32; i++) begin
            pend_vec[i] = (cnt[i] != '0);
        end
    end

    assign raw  = sb.id_valid & ((sb.rs1_used & pend_vec[sb.rs1_id]) |
                                 (sb.rs2_used & pend_vec[sb.rs2_id]));
    assign busy = sb.id_valid & sb.is_md_id & (md_busy != '0);
    assign fire = sb.id_valid & ~sb.stall_pipeline & ~sb.flush & ~raw & ~busy;

    always_comb begin
        issue_lat = '0;
        if (sb.is_load_id) begin
            issue_lat = tmr_t'(LOAD_BUBBLES);
        end else if (sb.is_md_id) begin
            issue_lat = tmr_t'(MD_LAT);
        end
    end

    // A squashed ID instruction never stalls, so flush masks raw/busy.
    always_comb begin
        load_en     = '1;
        ctrlmux_sel = 1'b0;
        sd          = SD_NONE;
        if (sb.stall_pipeline) begin
            load_en = '0;
            sd      = SD_MEM;
        end else if (sb.flush) begin
            sd      = SD_NONE;
        end else if (raw || busy) begin
            load_en[1:0] = 2'b00;
            ctrlmux_sel  = 1'b1;
            sd           = raw ? SD_RAW : SD_BUSY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < 32; i++) begin
                cnt[i] <= '0;
            end
            md_busy    <= '0;
            raw_stalls <= '0;
            mem_stalls <= '0;
            md_stalls  <= '0;
        end else begin
            if (!sb.stall_pipeline) begin
                // A fresh issue to rd replaces that entry's own decrement (latest latency wins).
                for (int i = 1; i < 32; i++) begin
                    if (fire && sb.rd_we_id && (sb.rd_id == 5'(i))) begin
                        cnt[i] <= issue_lat;
                    end else if (cnt[i] != '0) begin
                        cnt[i] <= cnt[i] - tmr_t'(1);
                    end
                end
                if (fire && sb.is_md_id) begin
                    md_busy <= tmr_t'(MD_LAT);
                end else if (md_busy != '0) begin
                    md_busy <= md_busy - tmr_t'(1);
                end
            end
            if ((sd == SD_MEM) && (mem_stalls != '1)) begin
                mem_stalls <= mem_stalls + CNT_W'(1);
            end
            if ((sd == SD_RAW) && (raw_stalls != '1)) begin
                raw_stalls <= raw_stalls + CNT_W'(1);
            end
            if ((sd == SD_BUSY) && (md_stalls != '1)) begin
                md_stalls <= md_stalls + CNT_W'(1);
            end
        end
    end

    assign sb.load_en     = load_en;
    assign sb.ctrlmux_sel = ctrlmux_sel;
    assign sb.cur_stall   = sb.stall_pipeline;
    assign sb.sd          = sd;
    assign sb.raw_stalls  = raw_stalls;
    assign sb.mem_stalls  = mem_stalls;
    assign sb.md_stalls   = md_stalls;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios with literal expectations plus a randomized run,
// all checked every cycle against a model that tracks per-register "ready at active cycle N" times.
module tb_hazard_scoreboard;
    localparam int NSTAGE = 5;
    localparam int LB     = 1;
    localparam int MDL    = 4;
    localparam int CW     = 4;
    localparam int SATMAX = (1 << CW) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    bit   chk_en = 1'b0;

    always #5 clk = ~clk;

    hazard_scoreboard_if #(.NSTAGE(NSTAGE), .CNT_W(CW)) bus ();

    hazard_scoreboard #(
        .NSTAGE(NSTAGE), .LOAD_BUBBLES(LB), .MD_LAT(MDL), .CNT_W(CW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .sb   (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: time is counted in unfrozen cycles; a result is pending until that count reaches ready_at.
    int act_cyc = 0;
    int ready_at [32];
    int md_ready = 0;
    int m_raw = 0, m_mem = 0, m_md = 0;
    logic [1:0] m_sd;

    function automatic bit pend(input logic [4:0] r);
        return (r != 5'd0) && (act_cyc < ready_at[r]);
    endfunction

    function automatic logic [1:0] exp_sd();
        bit raw, busy;
        raw  = bus.id_valid && ((bus.rs1_used && pend(bus.rs1_id)) ||
                                (bus.rs2_used && pend(bus.rs2_id)));
        busy = bus.id_valid && bus.is_md_id && (act_cyc < md_ready);
        if (bus.stall_pipeline) return 2'd2;
        if (bus.flush)          return 2'd0;
        if (raw)                return 2'd1;
        if (busy)               return 2'd3;
        return 2'd0;
    endfunction

    function automatic logic [NSTAGE-1:0] exp_len(input logic [1:0] s);
        if (s == 2'd2) return 5'b00000;
        if (s == 2'd1 || s == 2'd3) return 5'b11100;
        return 5'b11111;
    endfunction

    function automatic int sat_inc(input int v);
        return (v >= SATMAX) ? SATMAX : v + 1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_cyc  = 0;
            md_ready = 0;
            for (int i = 0; i < 32; i++) ready_at[i] = 0;
            m_raw = 0; m_mem = 0; m_md = 0;
        end else begin
            m_sd = exp_sd();
            if (bus.stall_pipeline) begin
                m_mem = sat_inc(m_mem);
            end else begin
                if (m_sd == 2'd1) m_raw = sat_inc(m_raw);
                if (m_sd == 2'd3) m_md  = sat_inc(m_md);
                if (bus.id_valid && !bus.flush && m_sd == 2'd0) begin
                    if (bus.rd_we_id && bus.rd_id != 5'd0)
                        ready_at[bus.rd_id] = act_cyc + 1 +
                            (bus.is_load_id ? LB : (bus.is_md_id ? MDL : 0));
                    if (bus.is_md_id) md_ready = act_cyc + 1 + MDL;
                end
                act_cyc++;
            end
        end
    end

    // Compare process: inputs change on the falling edge, outputs are sampled 1 time unit later.
    always @(negedge clk) begin
        logic [1:0] s;
        #1;
        if (chk_en) begin
            s = exp_sd();
            chk("sd",          32'(bus.sd),          32'(s));
            chk("load_en",     32'(bus.load_en),     32'(exp_len(s)));
            chk("ctrlmux_sel", 32'(bus.ctrlmux_sel), 32'(s == 2'd1 || s == 2'd3));
            chk("cur_stall",   32'(bus.cur_stall),   32'(bus.stall_pipeline));
            chk("raw_stalls",  32'(bus.raw_stalls),  32'(m_raw));
            chk("mem_stalls",  32'(bus.mem_stalls),  32'(m_mem));
            chk("md_stalls",   32'(bus.md_stalls),   32'(m_md));
        end
    end

    task automatic set_in(input bit v, input logic [4:0] r1, input bit u1,
                          input logic [4:0] r2, input bit u2, input logic [4:0] rd,
                          input bit we, input bit ld, input bit md, input bit st, input bit fl);
        bus.id_valid       = v;
        bus.rs1_id         = r1;
        bus.rs1_used       = u1;
        bus.rs2_id         = r2;
        bus.rs2_used       = u2;
        bus.rd_id          = rd;
        bus.rd_we_id       = we;
        bus.is_load_id     = ld;
        bus.is_md_id       = md;
        bus.stall_pipeline = st;
        bus.flush          = fl;
    endtask

    task automatic drive(input bit v, input logic [4:0] r1, input bit u1,
                         input logic [4:0] r2, input bit u2, input logic [4:0] rd,
                         input bit we, input bit ld, input bit md, input bit st, input bit fl);
        @(negedge clk);
        set_in(v, r1, u1, r2, u2, rd, we, ld, md, st, fl);
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        do_reset();
        chk_en = 1'b1;
        #3;
        chk("reset_load_en", 32'(bus.load_en), 32'h1f);
        chk("reset_sd",      32'(bus.sd),      32'd0);

        // Load-use: lw x5 ; add x6,x5,x0
        drive(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0);
        drive(1, 5, 1, 0, 1, 6, 1, 0, 0, 0, 0);
        chk("lu_sd",      32'(bus.sd),          32'd1);
        chk("lu_mux",     32'(bus.ctrlmux_sel), 32'd1);
        chk("lu_load_en", 32'(bus.load_en),     32'h1c);
        drive(1, 5, 1, 0, 1, 6, 1, 0, 0, 0, 0);
        chk("lu_issue_sd", 32'(bus.sd), 32'd0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("lu_raw_stalls", 32'(bus.raw_stalls), 32'd1);

        // Mul latency and a busy mul/div unit
        do_reset();
        drive(1, 1, 1, 2, 1, 7, 1, 0, 1, 0, 0);
        for (int k = 0; k < 4; k++) begin
            drive(1, 7, 1, 1, 1, 8, 1, 0, 0, 0, 0);
            chk("mul_raw_sd", 32'(bus.sd), 32'd1);
        end
        drive(1, 7, 1, 1, 1, 8, 1, 0, 0, 0, 0);
        chk("mul_issue_sd", 32'(bus.sd), 32'd0);
        drive(1, 1, 1, 2, 1, 9, 1, 0, 1, 0, 0);
        chk("mul2_first_sd", 32'(bus.sd), 32'd0);
        for (int k = 0; k < 4; k++) begin
            drive(1, 3, 1, 4, 1, 10, 1, 0, 1, 0, 0);
            chk("md_busy_sd",  32'(bus.sd),      32'd3);
            chk("md_busy_len", 32'(bus.load_en), 32'h1c);
        end
        drive(1, 3, 1, 4, 1, 10, 1, 0, 1, 0, 0);
        chk("md_issue_sd",  32'(bus.sd),         32'd0);
        chk("md_stalls",    32'(bus.md_stalls),  32'd4);
        chk("mul_raw_cnt",  32'(bus.raw_stalls), 32'd4);

        // Memory freeze overlapping a RAW stall
        do_reset();
        drive(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            drive(1, 5, 1, 0, 0, 6, 1, 0, 0, 1, 0);
            chk("frz_load_en",   32'(bus.load_en),   32'h00);
            chk("frz_sd",        32'(bus.sd),        32'd2);
            chk("frz_cur_stall", 32'(bus.cur_stall), 32'd1);
        end
        drive(1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0);
        chk("frz_raw_sd", 32'(bus.sd), 32'd1);
        drive(1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0);
        chk("frz_issue_sd", 32'(bus.sd),         32'd0);
        chk("frz_mem_cnt",  32'(bus.mem_stalls), 32'd3);
        chk("frz_raw_cnt",  32'(bus.raw_stalls), 32'd1);

        // Flush suppresses RAW; the scoreboard still ages
        do_reset();
        drive(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0);
        drive(1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 1);
        chk("fl_mux",     32'(bus.ctrlmux_sel), 32'd0);
        chk("fl_load_en", 32'(bus.load_en),     32'h1f);
        chk("fl_sd",      32'(bus.sd),          32'd0);
        drive(1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0);
        chk("fl_aged_sd", 32'(bus.sd), 32'd0);

        // x0 destination and unused source
        do_reset();
        drive(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        drive(1, 0, 1, 0, 1, 6, 1, 0, 0, 0, 0);
        chk("x0_sd", 32'(bus.sd), 32'd0);
        drive(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0);
        drive(1, 1, 1, 5, 0, 6, 1, 0, 0, 0, 0);
        chk("unused_rs2_sd", 32'(bus.sd), 32'd0);

        // Asynchronous reset in the middle of a mul RAW stall
        do_reset();
        drive(1, 1, 1, 2, 1, 7, 1, 0, 1, 0, 0);
        drive(1, 7, 1, 0, 0, 8, 1, 0, 0, 0, 0);
        chk("ar_pre_sd", 32'(bus.sd), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("ar_sd",      32'(bus.sd),         32'd0);
        chk("ar_load_en", 32'(bus.load_en),    32'h1f);
        chk("ar_raw_cnt", 32'(bus.raw_stalls), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 7, 1, 0, 0, 8, 1, 0, 0, 0, 0);
        chk("ar_post_sd",  32'(bus.sd),         32'd0);
        chk("ar_post_raw", 32'(bus.raw_stalls), 32'd0);

        // Randomized traffic over a small register window to provoke frequent hazards
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) do_reset();
            drive($urandom_range(0, 9) < 8,
                  5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
                  5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
                  5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2,
                  $urandom_range(0, 99) < 12, $urandom_range(0, 99) < 8);
        end

        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
